vend_settlement: RTL and testbench
==================================

VEND_SETTLEMENT -- requirements
Module: vend_settlement

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of price, credit and change.
REQ-002 Parameter K, default 16, SHALL set the discount lane count; total_discount is K*DATA_WIDTH bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sell_signal  input  1  SHALL be the sale-enable level from the vending FSM.
REQ-006 total_discount  input  K*DATA_WIDTH  SHALL be the discount bus; only lane 0 (bits DATA_WIDTH-1:0) is used.
REQ-007 price  input  DATA_WIDTH  SHALL be the list price of one item.
REQ-008 coin_valid  input  1  SHALL qualify coin_value for one cycle.
REQ-009 coin_value  input  8  SHALL be the inserted coin amount (zero-extended).
REQ-010 cancel  input  1  SHALL request a refund of all credit.
REQ-011 dispense_ready  input  1  SHALL be the motor-ready half of the dispense handshake.
REQ-012 coin_ready  output  1  SHALL be high when coins are accepted (IDLE or COLLECT).
REQ-013 dispense_valid  output  1  SHALL request a dispense.
REQ-014 change_valid  output  1  SHALL be a one-cycle change-return strobe.
REQ-015 change_amount  output  DATA_WIDTH  SHALL carry the refund; it is valid only with change_valid.
REQ-016 credit  output  DATA_WIDTH  SHALL be the current registered credit.
REQ-017 sales_count  output  16  SHALL count completed dispenses.
REQ-018 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, COLLECT, DISPENSE, CHANGE.
REQ-020 A sell edge SHALL be sell_signal==1 with the registered previous sell_signal==0.
REQ-021 Net price SHALL be price minus lane-0 discount, saturating at 0, captured in a register on the sell edge.
REQ-022 When coin_ready=1 and coin_valid=1, credit SHALL update next cycle to credit+coin_value, saturating at all-ones.
REQ-023 Coins arriving while coin_ready=0 SHALL be ignored.
REQ-024 IDLE SHALL go to COLLECT on a sell edge; a sell edge in any other state SHALL be ignored.
REQ-025 In COLLECT, when the registered credit >= net price, the FSM SHALL go to DISPENSE and set credit to credit minus net price on the same edge.
REQ-026 A zero net price SHALL reach DISPENSE one cycle after entering COLLECT.
REQ-027 cancel SHALL be honoured in IDLE and COLLECT only, and SHALL force the transition to CHANGE.
REQ-028 cancel SHALL take priority over the credit-sufficient check.
REQ-029 If a coin and cancel occur in the same cycle, the coin SHALL be included in the refund.
REQ-030 In DISPENSE, dispense_valid SHALL be 1 and SHALL hold until the cycle in which dispense_ready=1.
REQ-031 On the dispense handshake cycle, sales_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-032 After the handshake, the FSM SHALL go to CHANGE if credit != 0, else to IDLE.
REQ-033 In CHANGE, change_valid=1 and change_amount=credit for exactly one cycle; credit SHALL then be 0 and the state SHALL be IDLE.
REQ-034 A cancel in IDLE with credit==0 SHALL still produce a change_valid pulse with change_amount=0.
REQ-035 All outputs SHALL be registered or decoded only from registered state (no input-to-output combinational path).

Reset
REQ-036 reset_n=0 SHALL immediately force IDLE, with credit=0, net price=0, sales_count=0 and the previous-sell register=0.
REQ-037 During reset, dispense_valid=0, change_valid=0, change_amount=0, busy=0 and coin_ready=1.
REQ-038 Reset asserted mid-transaction SHALL discard credit without a change pulse.

Verification
REQ-039 price=100, discount lane0=30, sell edge, coins 50 then 25 -> DISPENSE entered, credit=5; with dispense_ready=1: sales_count=1, then change_valid with change_amount=5, then IDLE.
REQ-040 discount lane0=200 > price=100, sell edge, no coins -> DISPENSE one cycle after entering COLLECT, credit=0, no change pulse.
REQ-041 In COLLECT with credit=40, coin 10 and cancel in the same cycle -> CHANGE, change_amount=50, net price not charged.
REQ-042 dispense_ready held 0 for 5 cycles in DISPENSE -> dispense_valid stays 1, coin_ready=0, coins ignored, sales_count unchanged until ready.
REQ-043 sales_count=0xFFFF, one more sale -> sales_count=0; credit near all-ones plus coin 255 -> credit saturates at all-ones.
REQ-044 reset_n pulsed low in DISPENSE with credit=20 -> IDLE, credit=0, dispense_valid=0, no change_valid.

Source files
------------

// File: rtl/vend_settlement.sv
// Vending settlement controller: accumulates coin credit, applies a lane-0 discount to the price,
// handshakes a dispense with the motor, and returns any leftover credit as change.
module vend_settlement #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned K          = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sell_signal,
  input  logic [K*DATA_WIDTH-1:0] total_discount,
  input  logic [DATA_WIDTH-1:0]   price,
  input  logic                    coin_valid,
  input  logic [7:0]              coin_value,
  input  logic                    cancel,
  input  logic                    dispense_ready,
  output logic                    coin_ready,
  output logic                    dispense_valid,
  output logic                    change_valid,
  output logic [DATA_WIDTH-1:0]   change_amount,
  output logic [DATA_WIDTH-1:0]   credit,
  output logic [15:0]             sales_count,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StDispense, StChange} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   credit_q, credit_d;
  logic [DATA_WIDTH-1:0]   net_price_q, net_price_d;
  logic [15:0]             sales_q, sales_d;
  logic                    sell_prev_q;

  logic                    sell_edge;
  logic [DATA_WIDTH-1:0]   discount;
  logic [DATA_WIDTH-1:0]   net_price_calc;
  logic [DATA_WIDTH:0]     sum_wide;
  logic [DATA_WIDTH-1:0]   credit_plus;
  logic [DATA_WIDTH-1:0]   credit_in;
  logic                    coin_take;
  logic                    unused_discount;

  // Only lane 0 of the discount bus carries a value; the other lanes are deliberately ignored.
  assign unused_discount = ^total_discount;
  assign discount        = total_discount[DATA_WIDTH-1:0];
  assign net_price_calc  = (price > discount) ? (price - discount) : '0;
  assign sell_edge       = sell_signal & ~sell_prev_q;

  assign coin_take   = coin_ready & coin_valid;
  assign sum_wide    = {1'b0, credit_q} + {1'b0, DATA_WIDTH'(coin_value)};
  assign credit_plus = sum_wide[DATA_WIDTH] ? '1 : sum_wide[DATA_WIDTH-1:0];
  assign credit_in   = coin_take ? credit_plus : credit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      credit_q    <= '0;
      net_price_q <= '0;
      sales_q     <= '0;
      sell_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      net_price_q <= net_price_d;
      sales_q     <= sales_d;
      sell_prev_q <= sell_signal;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_in;
    net_price_d = net_price_q;
    sales_d     = sales_q;
    unique case (state_q)
      StIdle: begin
        if (cancel) begin
          state_d = StChange;
        end else if (sell_edge) begin
          state_d     = StCollect;
          net_price_d = net_price_calc;
        end
      end
      StCollect: begin
        // Cancel wins over a sufficient credit; any same-cycle coin rides along in credit_in.
        if (cancel) begin
          state_d = StChange;
        end else if (credit_q >= net_price_q) begin
          state_d  = StDispense;
          credit_d = credit_in - net_price_q;
        end
      end
      StDispense: begin
        if (dispense_ready) begin
          sales_d = sales_q + 16'd1;
          state_d = (credit_q != '0) ? StChange : StIdle;
        end
      end
      StChange: begin
        state_d  = StIdle;
        credit_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    coin_ready     = (state_q == StIdle) || (state_q == StCollect);
    dispense_valid = (state_q == StDispense);
    change_valid   = (state_q == StChange);
    change_amount  = (state_q == StChange) ? credit_q : '0;
    busy           = (state_q != StIdle);
    credit         = credit_q;
    sales_count    = sales_q;
  end

endmodule

// File: tb/tb_vend_settlement.sv
// Directed bench for vend_settlement with narrow data (8 bits) so credit saturation is reachable.
module tb_vend_settlement;

  localparam int unsigned DW = 8;
  localparam int unsigned KL = 2;

  logic             clk;
  logic             reset_n;
  logic             sell_signal;
  logic [KL*DW-1:0] total_discount;
  logic [DW-1:0]    price;
  logic             coin_valid;
  logic [7:0]       coin_value;
  logic             cancel;
  logic             dispense_ready;
  logic             coin_ready;
  logic             dispense_valid;
  logic             change_valid;
  logic [DW-1:0]    change_amount;
  logic [DW-1:0]    credit;
  logic [15:0]      sales_count;
  logic             busy;

  int n_checks;
  int n_fail;

  vend_settlement #(
    .DATA_WIDTH(DW),
    .K         (KL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sell_signal   (sell_signal),
    .total_discount(total_discount),
    .price         (price),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .cancel        (cancel),
    .dispense_ready(dispense_ready),
    .coin_ready    (coin_ready),
    .dispense_valid(dispense_valid),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .credit        (credit),
    .sales_count   (sales_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge, outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    sell_signal    = 1'b0;
    total_discount = '0;
    price          = '0;
    coin_valid     = 1'b0;
    coin_value     = '0;
    cancel         = 1'b0;
    dispense_ready = 1'b0;

    @(negedge clk);
    check_eq("rst_coin_ready", 32'(coin_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dispense_valid", 32'(dispense_valid), 32'd0);
    check_eq("rst_change_valid", 32'(change_valid), 32'd0);
    check_eq("rst_change_amount", 32'(change_amount), 32'd0);
    check_eq("rst_credit", 32'(credit), 32'd0);
    check_eq("rst_sales", 32'(sales_count), 32'd0);
    reset_n = 1'b1;

    // Net price 70 (lane 1 holds junk that must be ignored), coins 50 + 25.
    price          = 8'd100;
    total_discount = {8'hFF, 8'd30};
    sell_signal    = 1'b1;
    step();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_coin_ready", 32'(coin_ready), 32'd1);
    coin_valid = 1'b1;
    coin_value = 8'd50;
    step();
    check_eq("t1_credit50", 32'(credit), 32'd50);
    coin_value = 8'd25;
    step();
    check_eq("t1_credit75", 32'(credit), 32'd75);
    check_eq("t1_not_disp_yet", 32'(dispense_valid), 32'd0);
    coin_valid = 1'b0;
    step();
    check_eq("t1_dispense_valid", 32'(dispense_valid), 32'd1);
    check_eq("t1_credit_after", 32'(credit), 32'd5);
    check_eq("t1_coin_ready_disp", 32'(coin_ready), 32'd0);
    dispense_ready = 1'b1;
    step();
    check_eq("t1_sales", 32'(sales_count), 32'd1);
    check_eq("t1_change_valid", 32'(change_valid), 32'd1);
    check_eq("t1_change_amount", 32'(change_amount), 32'd5);
    dispense_ready = 1'b0;
    sell_signal    = 1'b0;
    step();
    check_eq("t1_change_done", 32'(change_valid), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_credit_zero", 32'(credit), 32'd0);

    // Discount exceeds price: net 0, dispense one cycle after COLLECT; then stall 5 cycles.
    total_discount = {8'h00, 8'd200};
    sell_signal    = 1'b1;
    step();
    check_eq("t2_collect", 32'(busy), 32'd1);
    check_eq("t2_no_disp", 32'(dispense_valid), 32'd0);
    step();
    check_eq("t2_dispense", 32'(dispense_valid), 32'd1);
    check_eq("t2_credit", 32'(credit), 32'd0);
    coin_valid = 1'b1;
    coin_value = 8'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_hold_dv", 32'(dispense_valid), 32'd1);
      check_eq("t2_hold_cr", 32'(coin_ready), 32'd0);
      check_eq("t2_hold_credit", 32'(credit), 32'd0);
      check_eq("t2_hold_sales", 32'(sales_count), 32'd1);
    end
    coin_valid     = 1'b0;
    dispense_ready = 1'b1;
    step();
    check_eq("t2_sales", 32'(sales_count), 32'd2);
    check_eq("t2_no_change", 32'(change_valid), 32'd0);
    check_eq("t2_idle", 32'(busy), 32'd0);
    dispense_ready = 1'b0;
    sell_signal    = 1'b0;
    step();

    // Cancel in COLLECT with a coming coin: refund 40 + 10, nothing charged.
    total_discount = '0;
    sell_signal    = 1'b1;
    step();
    coin_valid = 1'b1;
    coin_value = 8'd40;
    step();
    check_eq("t3_credit40", 32'(credit), 32'd40);
    coin_value = 8'd10;
    cancel     = 1'b1;
    step();
    check_eq("t3_change_valid", 32'(change_valid), 32'd1);
    check_eq("t3_change_amount", 32'(change_amount), 32'd50);
    check_eq("t3_sales", 32'(sales_count), 32'd2);
    coin_valid  = 1'b0;
    cancel      = 1'b0;
    sell_signal = 1'b0;
    step();
    check_eq("t3_idle", 32'(busy), 32'd0);
    check_eq("t3_credit_zero", 32'(credit), 32'd0);

    // Cancel in IDLE with zero credit still pulses change.
    cancel = 1'b1;
    step();
    check_eq("t4_change_valid", 32'(change_valid), 32'd1);
    check_eq("t4_change_amount", 32'(change_amount), 32'd0);
    cancel = 1'b0;
    step();
    check_eq("t4_done", 32'(change_valid), 32'd0);

    // Credit saturation at all-ones.
    coin_valid = 1'b1;
    coin_value = 8'd200;
    step();
    check_eq("t5_credit200", 32'(credit), 32'd200);
    coin_value = 8'd255;
    step();
    check_eq("t5_saturate", 32'(credit), 32'd255);
    coin_valid = 1'b0;
    cancel     = 1'b1;
    step();
    check_eq("t5_refund", 32'(change_amount), 32'd255);
    cancel = 1'b0;
    step();

    // Sales counter wrap from 0xFFFF.
    force dut.sales_q = 16'hFFFF;
    #1;
    release dut.sales_q;
    check_eq("t6_preset", 32'(sales_count), 32'h0000_FFFF);
    price       = 8'd0;
    sell_signal = 1'b1;
    step();
    step();
    check_eq("t6_dispense", 32'(dispense_valid), 32'd1);
    dispense_ready = 1'b1;
    step();
    check_eq("t6_wrap", 32'(sales_count), 32'd0);
    check_eq("t6_idle", 32'(busy), 32'd0);
    dispense_ready = 1'b0;
    sell_signal    = 1'b0;
    step();

    // Reset in DISPENSE with credit 20 discards it silently.
    price          = 8'd50;
    total_discount = {8'h00, 8'd30};
    sell_signal    = 1'b1;
    step();
    coin_valid = 1'b1;
    coin_value = 8'd40;
    step();
    coin_valid = 1'b0;
    step();
    check_eq("t7_dispense", 32'(dispense_valid), 32'd1);
    check_eq("t7_credit20", 32'(credit), 32'd20);
    reset_n     = 1'b0;
    sell_signal = 1'b0;
    #1;
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_dv", 32'(dispense_valid), 32'd0);
    check_eq("t7_rst_credit", 32'(credit), 32'd0);
    check_eq("t7_rst_cv", 32'(change_valid), 32'd0);
    check_eq("t7_rst_coin_ready", 32'(coin_ready), 32'd1);
    check_eq("t7_rst_sales", 32'(sales_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_eq("t7_post_cv", 32'(change_valid), 32'd0);
    check_eq("t7_post_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
